spart_driver: RTL and testbench

SPART_DRIVER -- requirements
Module: spart_driver

---
 rtl/spart_driver.sv | 129 ++++++++++++
 tb/tb_spart_driver.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/spart_driver.sv
// SPART bus initiator: programs the baud divisor, then echoes every received byte.
// Optional macro SPART_DRIVER_UPCASE_EN converts ASCII 'a'..'z' to upper case in the echo.
module spart_driver (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] br_cfg,
    input  logic       rda,
    input  logic       tbr,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic [7:0] last_rx,
    output logic [7:0] echo_cnt
);

    typedef enum logic [2:0] {
        CFG_LO,
        CFG_HI,
        IDLE,
        READ,
        WAIT_TBR,
        WRITE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  br_q, br_d;
    logic [7:0]  last_rx_q, last_rx_d;
    logic [7:0]  echo_cnt_q, echo_cnt_d;
    logic [15:0] divisor;
    logic [7:0]  echo_byte;
    logic [7:0]  dat_out;
    logic        cs, rw;
    logic [1:0]  addr;

    always_comb begin
        case (br_q)
            2'b00:   divisor = 16'h028B;
            2'b01:   divisor = 16'h0145;
            2'b10:   divisor = 16'h00A2;
            default: divisor = 16'h0050;
        endcase
    end

`ifdef SPART_DRIVER_UPCASE_EN
    assign echo_byte = (last_rx_q >= 8'h61 && last_rx_q <= 8'h7A) ? last_rx_q - 8'h20 : last_rx_q;
`else
    assign echo_byte = last_rx_q;
`endif

    always_comb begin
        state_d    = state_q;
        br_d       = br_q;
        last_rx_d  = last_rx_q;
        echo_cnt_d = echo_cnt_q;
        cs         = 1'b0;
        rw         = 1'b1;
        addr       = 2'b00;
        dat_out    = 8'h00;
        case (state_q)
            CFG_LO: begin
                cs      = 1'b1;
                rw      = 1'b0;
                addr    = 2'b10;
                dat_out = divisor[7:0];
                state_d = CFG_HI;
            end
            CFG_HI: begin
                cs      = 1'b1;
                rw      = 1'b0;
                addr    = 2'b11;
                dat_out = divisor[15:8];
                state_d = IDLE;
            end
            IDLE: begin
                // A pending byte wins; a baud change waits for the next idle cycle.
                // br_q is loaded on the way into CFG_LO so both divisor bytes share one value.
                if (rda) begin
                    state_d = READ;
                end else if (br_cfg != br_q) begin
                    br_d    = br_cfg;
                    state_d = CFG_LO;
                end
            end
            READ: begin
                cs        = 1'b1;
                rw        = 1'b1;
                addr      = 2'b00;
                last_rx_d = databus;
                state_d   = WAIT_TBR;
            end
            WAIT_TBR: begin
                if (tbr) state_d = WRITE;
            end
            WRITE: begin
                cs         = 1'b1;
                rw         = 1'b0;
                addr       = 2'b00;
                dat_out    = echo_byte;
                echo_cnt_d = echo_cnt_q + 8'd1;
                state_d    = IDLE;
            end
            default: state_d = CFG_LO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= CFG_LO;
            br_q       <= br_cfg;
            last_rx_q  <= 8'h00;
            echo_cnt_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            br_q       <= br_d;
            last_rx_q  <= last_rx_d;
            echo_cnt_q <= echo_cnt_d;
        end
    end

    // Bus strobes are held idle while reset is asserted, so no write leaks out mid-reset.
    assign iocs     = cs & rst_n;
    assign iorw     = rw | ~rst_n;
    assign ioaddr   = rst_n ? addr : 2'b00;
    assign databus  = (iocs && !iorw) ? dat_out : 8'hzz;
    assign last_rx  = last_rx_q;
    assign echo_cnt = echo_cnt_q;

endmodule

// File: tb/tb_spart_driver.sv
// Directed bench for spart_driver acting as a SPART responder on the shared data bus.
module tb_spart_driver;

    logic       clk;
    logic       rst_n;
    logic [1:0] br_cfg;
    logic       rda;
    logic       tbr;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic [7:0] last_rx;
    logic [7:0] echo_cnt;

    logic [7:0] rx_byte;
    logic [7:0] exp_cnt;
    int         n_vec;
    int         n_bad;

    // Responder returns rx_byte on reads and 00 whenever the DUT must not drive.
    assign databus = (iocs && !iorw) ? 8'hzz : (iocs ? rx_byte : 8'h00);

    spart_driver dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .br_cfg   (br_cfg),
        .rda      (rda),
        .tbr      (tbr),
        .iocs     (iocs),
        .iorw     (iorw),
        .ioaddr   (ioaddr),
        .databus  (databus),
        .last_rx  (last_rx),
        .echo_cnt (echo_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_echo(input logic [7:0] b);
`ifdef SPART_DRIVER_UPCASE_EN
        return (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
`else
        return b;
`endif
    endfunction

    // Called at a falling edge while the DUT is in IDLE; returns at a falling edge in IDLE.
    task automatic echo(input logic [7:0] b, input int delay, input logic chg_cfg);
        rx_byte = b;
        tbr     = (delay == 0);
        rda     = 1'b1;
        @(negedge clk);
        rda = 1'b0;
        check_vec("rd_cs",   {15'd0, iocs}, 16'd1);
        check_vec("rd_rw",   {15'd0, iorw}, 16'd1);
        check_vec("rd_addr", {14'd0, ioaddr}, 16'd0);
        check_vec("rd_bus",  {8'd0, databus}, {8'd0, b});
        @(negedge clk);
        if (chg_cfg) br_cfg = 2'b11;
        check_vec("wt_lastrx", {8'd0, last_rx}, {8'd0, b});
        check_vec("wt_cs",     {15'd0, iocs}, 16'd0);
        check_vec("wt_bus",    {8'd0, databus}, 16'd0);
        if (delay > 0) begin
            repeat (delay - 1) begin
                @(negedge clk);
                check_vec("wt_hold", {15'd0, iocs}, 16'd0);
            end
            tbr = 1'b1;
        end
        @(negedge clk);
        tbr = 1'b0;
        check_vec("wr_cs",   {15'd0, iocs}, 16'd1);
        check_vec("wr_rw",   {15'd0, iorw}, 16'd0);
        check_vec("wr_addr", {14'd0, ioaddr}, 16'd0);
        check_vec("wr_bus",  {8'd0, databus}, {8'd0, exp_echo(b)});
        exp_cnt = exp_cnt + 8'd1;
        @(negedge clk);
        check_vec("id_cnt",    {8'd0, echo_cnt}, {8'd0, exp_cnt});
        check_vec("id_cs",     {15'd0, iocs}, 16'd0);
        check_vec("id_bus",    {8'd0, databus}, 16'd0);
        check_vec("id_lastrx", {8'd0, last_rx}, {8'd0, b});
    endtask

    task automatic expect_cfg(input logic [15:0] div);
        check_vec("cfglo_cs",   {15'd0, iocs}, 16'd1);
        check_vec("cfglo_rw",   {15'd0, iorw}, 16'd0);
        check_vec("cfglo_addr", {14'd0, ioaddr}, 16'd2);
        check_vec("cfglo_bus",  {8'd0, databus}, {8'd0, div[7:0]});
        @(negedge clk);
        check_vec("cfghi_cs",   {15'd0, iocs}, 16'd1);
        check_vec("cfghi_addr", {14'd0, ioaddr}, 16'd3);
        check_vec("cfghi_bus",  {8'd0, databus}, {8'd0, div[15:8]});
        @(negedge clk);
        check_vec("cfg_idle", {15'd0, iocs}, 16'd0);
    endtask

    task automatic expect_reset();
        check_vec("rst_cs",     {15'd0, iocs}, 16'd0);
        check_vec("rst_rw",     {15'd0, iorw}, 16'd1);
        check_vec("rst_addr",   {14'd0, ioaddr}, 16'd0);
        check_vec("rst_lastrx", {8'd0, last_rx}, 16'd0);
        check_vec("rst_cnt",    {8'd0, echo_cnt}, 16'd0);
        check_vec("rst_bus",    {8'd0, databus}, 16'd0);
    endtask

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        exp_cnt = 8'h00;
        rst_n   = 1'b0;
        br_cfg  = 2'b00;
        rda     = 1'b0;
        tbr     = 1'b0;
        rx_byte = 8'h00;
        repeat (3) @(negedge clk);
        expect_reset();

        // Configuration right after release, then a minimum-latency echo.
        rst_n = 1'b1;
        #1;
        expect_cfg(16'h028B);
        echo(8'hB4, 0, 1'b0);
        check_vec("cnt_first", {8'd0, echo_cnt}, 16'h0001);

        // Lower-case byte with transmitter held busy for 50 cycles.
        echo(8'h61, 50, 1'b0);
        check_vec("lastrx_raw", {8'd0, last_rx}, 16'h0061);

        // Baud change during WAIT_TBR finishes the echo first.
        echo(8'h7A, 3, 1'b1);
        @(negedge clk);
        expect_cfg(16'h0050);

        // Simultaneous rda and baud change: read wins, reconfiguration follows.
        br_cfg = 2'b01;
        echo(8'h20, 0, 1'b0);
        @(negedge clk);
        expect_cfg(16'h0145);
        br_cfg = 2'b10;
        @(negedge clk);
        expect_cfg(16'h00A2);

        // 256 back-to-back echoes bring the counter back to its starting value.
        begin
            logic [7:0] start_cnt;
            start_cnt = exp_cnt;
            for (int i = 0; i < 256; i++) begin
                logic [7:0] iv;
                iv = i[7:0];
                echo(iv ^ 8'h5A, 0, 1'b0);
            end
            check_vec("cnt_wrap", {8'd0, echo_cnt}, {8'd0, start_cnt});
        end

        // Reset during WAIT_TBR abandons the echo.
        rx_byte = 8'hC3;
        rda     = 1'b1;
        @(negedge clk);
        rda = 1'b0;
        @(negedge clk);
        check_vec("abort_wait", {15'd0, iocs}, 16'd0);
        tbr   = 1'b1;
        rst_n = 1'b0;
        #1;
        check_vec("abort_cs", {15'd0, iocs}, 16'd0);
        @(negedge clk);
        expect_reset();
        tbr = 1'b0;
        @(negedge clk);
        expect_reset();
        exp_cnt = 8'h00;
        rst_n   = 1'b1;
        #1;
        expect_cfg(16'h00A2);
        echo(8'h41, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
